ren_conv_mc_engine: RTL and testbench
=====================================

// Module: ren_conv_mc_engine
// PURPOSE
//  Next-gen convolution engine core behind the Wishbone wrapper's register, image, kernel and result decode.
//  Generalises the fixed 3-channel engine:
//  - parametrised channel count and pixel width; configurable stride
//  - signed-kernel mode with optional ReLU; result shift with saturation and a sticky overflow flag
//  - max-pool that handles odd output counts
//  Reads image/kernel DFFRAMs through 1-cycle-latency read ports and writes pooled results sequentially.
// PARAMETERS
//  CH              3   channels packed per RAM word (ch0 at [PIX_W-1:0])
//  PIX_W           8   bits per pixel/weight
//  KERN_COL_WIDTH  3   width of kern_cols_m1 (up to 8 kernel columns)
//  COL_WIDTH       8   width of cols_m1 and stride
//  KERN_CNT_WIDTH  3   width of kerns_m1 (up to 8 kernels)
//  IMG_ADDR_WIDTH  8   image RAM address width
//  KERN_ADDR_WIDTH 5   kernel RAM address width
//  RSLT_ADDR_WIDTH 8   result RAM address width
//  OUT_W           20  result word width
// PORTS
//  wb_clk_i        in   1                 clock
//  wb_rst_i        in   1                 reset, asynchronous, active-low
//  soft_rst        in   1                 synchronous soft reset (reg bit 1)
//  start           in   1                 level start (reg bit 2); launch on rising edge
//  kern_cols_m1    in   KERN_COL_WIDTH    kernel columns minus 1
//  cols_m1         in   COL_WIDTH         input columns to scan minus 1
//  kerns_m1        in   KERN_CNT_WIDTH    kernel count minus 1
//  stride          in   COL_WIDTH         column step; 0 treated as 1
//  kern_addr_mode  in   1                 kernel base = ks*4 (0) or ks*8 (1)
//  shift           in   4                 arithmetic right shift of accumulator
//  en_max_pool     in   1                 pairwise max of consecutive outputs
//  signed_mode     in   1                 weights two's complement; pixels always unsigned
//  en_relu         in   1                 clamp negative results to 0
//  mask            in   CH                per-channel enable
//  img_rd_en       out  1                 image RAM read strobe
//  img_addr        out  IMG_ADDR_WIDTH    image RAM address
//  img_rdata       in   CH*PIX_W          image data, valid 1 cycle after img_rd_en
//  kern_rd_en      out  1                 kernel RAM read strobe
//  kern_addr       out  KERN_ADDR_WIDTH   kernel RAM address
//  kern_rdata      in   CH*PIX_W          kernel data, valid 1 cycle after kern_rd_en
//  rslt_we         out  1                 result write strobe
//  rslt_addr       out  RSLT_ADDR_WIDTH   result address
//  rslt_wdata      out  OUT_W             result data
//  busy            out  1                 engine running
//  done            out  1                 run finished (status bit 0)
//  overflow        out  1                 sticky saturation flag
// BEHAVIOUR
//  - Reset (async or soft_rst): state IDLE; every output 0; accumulators and counters cleared.
//    Soft reset mid-run aborts the run; no further result writes occur.
//  - FSM: IDLE -> RUN (start rising edge and !done) -> POST -> WRITE -> RUN | DONE -> IDLE (start low).
//    Start is ignored while busy or done.
//  - done holds until start is deasserted. busy is high from the cycle after launch until DONE.
//  - Loops: ks=0..kerns_m1; c=0,stride,.. while c<=cols_m1; kc=0..kern_cols_m1.
//    RUN issues one read pair per cycle: img_addr=c+kc, kern_addr=ks*(4<<mode)+kc.
//    Both addresses wrap modulo their widths.
//  - MAC (one cycle after data returns): acc += sum over ch with mask[ch] of pix*wt.
//    pix is always unsigned; wt is signed if signed_mode, else unsigned.
//    ACC_W = 2*PIX_W+2+$clog2(CH)+KERN_COL_WIDTH, signed.
//  - POST: y = acc>>>shift; y = 0 if en_relu and y<0.
//    Saturate y to OUT_W: unsigned range if !signed_mode, signed range if signed_mode.
//    Saturation sets overflow. overflow clears only on reset or on a new launch.
//  - Timing per output column: K read cycles + 1 data cycle + 1 MAC drain + POST = K+3 cycles.
//  - Pool off: every output is written.
//    Pool on: even-index outputs are held; odd-index outputs write max(held,cur).
//    A trailing unpaired output within a kernel is written alone.
//  - Pairs never cross kernel boundaries.
//  - rslt_addr starts at 0 per run and increments once per write; wraps modulo 2^RSLT_ADDR_WIDTH.
//    rslt_we is a 1-cycle pulse.
//  - After the last write: DONE; done=1, busy=0 in the same cycle.
// STRUCTURE
//  - Package ren_conv_pkg: FSM state enum; ACC_W function; KERN_STRIDE_4/8 constants.
//  - Sub-module ren_conv_mac_lane: CH-wide masked multiply, signed/unsigned select, adder tree.
//    One instance; the FSM, counters, post-processing and pool register live in the top.
// TESTING
//  CH=3, PIX_W=8, OUT_W=20, shift=0, mask=111, mode 0 unless noted.
//  T1: image[i]={1,1,1}, kernels=1, K=2, cols_m1=3, stride=1, pool off
//      -> 4 writes of 6 at addr 0..3; each column K+3=5 cycles.
//  T2: image[i]={i,i,i}, kernels=1, K=2, cols_m1=3, pool on
//      -> conv 3,9,15,21 -> writes 9,21 at addr 0,1.
//  T3: as T2 with cols_m1=4, stride=2
//      -> conv 3,15,27 -> writes 15,27 (unpaired tail written alone).
//  T4: T2 data, weights 0xFF, signed_mode=1, pool off
//      -> writes -3,-9,-15,-21 (20-bit two's complement); with en_relu=1 -> all 0.
//  T5: all pixels/weights 255, K=8, cols_m1=0
//      -> 1560600 saturates to 0xFFFFF with overflow=1; shift=1 -> 780300, overflow=0.
//  T6: soft_rst mid-run -> no further rslt_we, busy=done=0.
//      start held high after done -> no relaunch; toggle start -> new run from addr 0.

Source files
------------

// File: rtl/ren_conv_pkg.sv
// Shared definitions for the multi-channel convolution engine.
//   state_t        : engine FSM states
//   acc_w()        : accumulator width from channel count, pixel width and
//                    kernel-column counter width
//   KERN_STRIDE_4/8: kernel RAM words per kernel for the two address modes
package ren_conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_POST  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int KERN_STRIDE_4 = 4;
  localparam int KERN_STRIDE_8 = 8;

  // Signed product is 2*PIX_W+2 bits (unsigned pixel x optionally signed
  // weight, both widened by one bit); the channel sum adds clog2(CH) bits and
  // the kernel-column accumulation adds KERN_COL_WIDTH bits.
  function automatic int acc_w(input int ch, input int pix_w, input int kcw);
    return 2 * pix_w + 2 + $clog2(ch) + kcw;
  endfunction

endpackage

// File: rtl/ren_conv_mac_lane.sv
// CH-wide masked multiply and channel sum.
//   pix         : CH packed unsigned pixels (ch0 in the low bits)
//   wt          : CH packed weights, two's complement when signed_mode
//   mask        : per-channel enable; disabled channels contribute 0
//   signed_mode : weight interpretation select
//   sum         : signed sum of the enabled pixel*weight products
module ren_conv_mac_lane #(
  parameter int CH    = 3,
  parameter int PIX_W = 8,
  parameter int SUM_W = 2 * PIX_W + 2 + $clog2(CH)
) (
  input  logic [CH*PIX_W-1:0]    pix,
  input  logic [CH*PIX_W-1:0]    wt,
  input  logic [CH-1:0]          mask,
  input  logic                   signed_mode,
  output logic signed [SUM_W-1:0] sum
);

  localparam int PW = 2 * PIX_W + 2;

  logic signed [PIX_W:0]  px   [CH];
  logic signed [PIX_W:0]  w    [CH];
  logic signed [PW-1:0]   prod [CH];

  for (genvar i = 0; i < CH; i++) begin : g_ch
    // Pixels are always unsigned; weights take their MSB as sign only in
    // signed mode, so one signed multiplier serves both modes.
    assign px[i]   = $signed({1'b0, pix[i*PIX_W +: PIX_W]});
    assign w[i]    = $signed({signed_mode & wt[i*PIX_W+PIX_W-1], wt[i*PIX_W +: PIX_W]});
    assign prod[i] = mask[i] ? (PW'(px[i]) * PW'(w[i])) : '0;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < CH; i++) begin
      sum = sum + SUM_W'(prod[i]);
    end
  end

endmodule

// File: rtl/ren_conv_mc_engine.sv
// Multi-channel convolution engine core.
//   wb_clk_i / wb_rst_i : clock, asynchronous active-low reset
//   soft_rst, start     : synchronous abort, level start (launch on rising edge)
//   kern_cols_m1, cols_m1, kerns_m1, stride, kern_addr_mode : scan geometry
//   shift, en_max_pool, signed_mode, en_relu, mask           : datapath options
//   img_* / kern_*      : 1-cycle-latency RAM read ports
//   rslt_*              : sequential result write port
//   busy, done, overflow: status
module ren_conv_mc_engine #(
  parameter int CH              = 3,
  parameter int PIX_W           = 8,
  parameter int KERN_COL_WIDTH  = 3,
  parameter int COL_WIDTH       = 8,
  parameter int KERN_CNT_WIDTH  = 3,
  parameter int IMG_ADDR_WIDTH  = 8,
  parameter int KERN_ADDR_WIDTH = 5,
  parameter int RSLT_ADDR_WIDTH = 8,
  parameter int OUT_W           = 20
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       soft_rst,
  input  logic                       start,
  input  logic [KERN_COL_WIDTH-1:0]  kern_cols_m1,
  input  logic [COL_WIDTH-1:0]       cols_m1,
  input  logic [KERN_CNT_WIDTH-1:0]  kerns_m1,
  input  logic [COL_WIDTH-1:0]       stride,
  input  logic                       kern_addr_mode,
  input  logic [3:0]                 shift,
  input  logic                       en_max_pool,
  input  logic                       signed_mode,
  input  logic                       en_relu,
  input  logic [CH-1:0]              mask,
  output logic                       img_rd_en,
  output logic [IMG_ADDR_WIDTH-1:0]  img_addr,
  input  logic [CH*PIX_W-1:0]        img_rdata,
  output logic                       kern_rd_en,
  output logic [KERN_ADDR_WIDTH-1:0] kern_addr,
  input  logic [CH*PIX_W-1:0]        kern_rdata,
  output logic                       rslt_we,
  output logic [RSLT_ADDR_WIDTH-1:0] rslt_addr,
  output logic [OUT_W-1:0]           rslt_wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow
);

  import ren_conv_pkg::*;

  localparam int ACC_W = acc_w(CH, PIX_W, KERN_COL_WIDTH);
  localparam int SUM_W = 2 * PIX_W + 2 + $clog2(CH);
  localparam int RC_W  = KERN_COL_WIDTH + 1;
  localparam int CN_W  = COL_WIDTH + 1;

  state_t                      state, state_nx;
  logic                        start_q;
  logic [KERN_CNT_WIDTH-1:0]   ks;
  logic [COL_WIDTH-1:0]        c;
  logic [RC_W-1:0]             rc;
  logic                        vld_p1;
  logic signed [ACC_W-1:0]     acc;
  logic signed [SUM_W-1:0]     lane_sum;
  logic                        pool_phase;
  logic                        wr_pend;
  logic [OUT_W-1:0]            held;
  logic [OUT_W-1:0]            wdata;
  logic [RSLT_ADDR_WIDTH-1:0]  waddr;
  logic                        ovf;

  logic                        launch;
  logic                        rd_act;
  logic [KERN_COL_WIDTH-1:0]   kc;
  logic [CN_W-1:0]             step;
  logic [CN_W-1:0]             c_next;
  logic                        last_col;
  logic                        last_ks;
  logic [OUT_W:0]              post_res;
  logic [OUT_W-1:0]            post_y;
  logic                        post_sat;

  // Shift, optional ReLU, then clamp to the unsigned or signed OUT_W range.
  // Returns {saturated, value}.
  function automatic logic [OUT_W:0] post_proc(input logic signed [ACC_W-1:0] a,
                                               input logic [3:0] sh,
                                               input logic sgn,
                                               input logic relu);
    logic signed [ACC_W-1:0] y;
    logic signed [63:0]      ye;
    logic signed [63:0]      hi;
    logic signed [63:0]      lo;
    logic                    sat;
    y = a >>> sh;
    if (relu && y[ACC_W-1]) y = '0;
    ye  = {{(64-ACC_W){y[ACC_W-1]}}, y};
    hi  = sgn ? ((64'sd1 <<< (OUT_W-1)) - 64'sd1) : ((64'sd1 <<< OUT_W) - 64'sd1);
    lo  = sgn ? -(64'sd1 <<< (OUT_W-1)) : 64'sd0;
    sat = 1'b0;
    if (ye > hi) begin
      ye  = hi;
      sat = 1'b1;
    end else if (ye < lo) begin
      ye  = lo;
      sat = 1'b1;
    end
    return {sat, ye[OUT_W-1:0]};
  endfunction

  function automatic logic [OUT_W-1:0] pool_max(input logic [OUT_W-1:0] a,
                                                input logic [OUT_W-1:0] b,
                                                input logic sgn);
    if (sgn) return ($signed(a) > $signed(b)) ? a : b;
    return (a > b) ? a : b;
  endfunction

  ren_conv_mac_lane #(
    .CH    (CH),
    .PIX_W (PIX_W),
    .SUM_W (SUM_W)
  ) u_lane (
    .pix         (img_rdata),
    .wt          (kern_rdata),
    .mask        (mask),
    .signed_mode (signed_mode),
    .sum         (lane_sum)
  );

  assign launch   = (state == ST_IDLE) && start && !start_q;
  // rc runs 0..K: the first K cycles issue reads, the last waits for data.
  assign rd_act   = (rc <= RC_W'(kern_cols_m1));
  assign kc       = rc[KERN_COL_WIDTH-1:0];
  assign step     = (stride == '0) ? CN_W'(1) : CN_W'(stride);
  assign c_next   = CN_W'(c) + step;
  assign last_col = (c_next > CN_W'(cols_m1));
  assign last_ks  = (ks == kerns_m1);
  assign post_res = post_proc(acc, shift, signed_mode, en_relu);
  assign post_y   = post_res[OUT_W-1:0];
  assign post_sat = post_res[OUT_W];

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i)     state <= ST_IDLE;
    else if (soft_rst) state <= ST_IDLE;
    else               state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (launch) state_nx = ST_RUN;
      ST_RUN:   if (!rd_act) state_nx = ST_POST;
      ST_POST:  state_nx = ST_WRITE;
      ST_WRITE: state_nx = (last_col && last_ks) ? ST_DONE : ST_RUN;
      ST_DONE:  if (!start) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    img_rd_en  = 1'b0;
    kern_rd_en = 1'b0;
    img_addr   = '0;
    kern_addr  = '0;
    rslt_we    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_RUN: begin
        busy = 1'b1;
        if (rd_act) begin
          img_rd_en  = 1'b1;
          kern_rd_en = 1'b1;
          img_addr   = IMG_ADDR_WIDTH'(c) + IMG_ADDR_WIDTH'(kc);
          kern_addr  = KERN_ADDR_WIDTH'(ks)
                     * KERN_ADDR_WIDTH'(kern_addr_mode ? KERN_STRIDE_8 : KERN_STRIDE_4)
                     + KERN_ADDR_WIDTH'(kc);
        end
      end
      ST_POST:  busy = 1'b1;
      ST_WRITE: begin
        busy    = 1'b1;
        rslt_we = wr_pend;
      end
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign rslt_addr  = waddr;
  assign rslt_wdata = wdata;
  assign overflow   = ovf;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      start_q    <= 1'b0;
      ks         <= '0;
      c          <= '0;
      rc         <= '0;
      vld_p1     <= 1'b0;
      acc        <= '0;
      pool_phase <= 1'b0;
      wr_pend    <= 1'b0;
      held       <= '0;
      wdata      <= '0;
      waddr      <= '0;
      ovf        <= 1'b0;
    end else if (soft_rst) begin
      // Track start so a level left high across the abort needs a fresh edge.
      start_q    <= start;
      ks         <= '0;
      c          <= '0;
      rc         <= '0;
      vld_p1     <= 1'b0;
      acc        <= '0;
      pool_phase <= 1'b0;
      wr_pend    <= 1'b0;
      held       <= '0;
      wdata      <= '0;
      waddr      <= '0;
      ovf        <= 1'b0;
    end else begin
      start_q <= start;
      // p0: read issued; p1: RAM data valid and accumulated
      vld_p1  <= img_rd_en;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            ks         <= '0;
            c          <= '0;
            rc         <= '0;
            acc        <= '0;
            waddr      <= '0;
            ovf        <= 1'b0;
            pool_phase <= 1'b0;
            wr_pend    <= 1'b0;
          end
        end
        ST_RUN: begin
          rc <= rc + RC_W'(1);
          if (vld_p1) acc <= acc + ACC_W'(lane_sum);
        end
        // post: shift/ReLU/saturate, then pool decision
        ST_POST: begin
          ovf <= ovf | post_sat;
          if (!en_max_pool) begin
            wdata      <= post_y;
            wr_pend    <= 1'b1;
            pool_phase <= 1'b0;
          end else if (!pool_phase) begin
            // Even output: hold it, unless it is the unpaired tail of a kernel.
            held       <= post_y;
            wdata      <= post_y;
            wr_pend    <= last_col;
            pool_phase <= !last_col;
          end else begin
            wdata      <= pool_max(held, post_y, signed_mode);
            wr_pend    <= 1'b1;
            pool_phase <= 1'b0;
          end
        end
        // write: emit result, advance column/kernel counters
        ST_WRITE: begin
          if (wr_pend) waddr <= waddr + RSLT_ADDR_WIDTH'(1);
          wr_pend <= 1'b0;
          acc     <= '0;
          rc      <= '0;
          if (last_col) begin
            c  <= '0;
            ks <= ks + KERN_CNT_WIDTH'(1);
          end else begin
            c  <= c_next[COL_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ren_conv_mc_engine.sv
module tb_ren_conv_mc_engine;

  localparam int LIMIT = 5000;

  logic        clk = 1'b0;
  logic        rst_n, soft_rst, start;
  logic [2:0]  kern_cols_m1;
  logic [7:0]  cols_m1;
  logic [2:0]  kerns_m1;
  logic [7:0]  stride;
  logic        kern_addr_mode;
  logic [3:0]  shift;
  logic        en_max_pool, signed_mode, en_relu;
  logic [2:0]  mask;
  logic        img_rd_en, kern_rd_en, rslt_we, busy, done, overflow;
  logic [7:0]  img_addr;
  logic [4:0]  kern_addr;
  logic [23:0] img_rdata, kern_rdata;
  logic [7:0]  rslt_addr;
  logic [19:0] rslt_wdata;

  logic [23:0] img_mem  [256];
  logic [23:0] kern_mem [32];

  logic [19:0] got_d [$];
  logic [7:0]  got_a [$];
  int          got_c [$];
  logic [19:0] exp_d [$];
  bit          exp_ovf;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ren_conv_mc_engine dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst_n),
    .soft_rst       (soft_rst),
    .start          (start),
    .kern_cols_m1   (kern_cols_m1),
    .cols_m1        (cols_m1),
    .kerns_m1       (kerns_m1),
    .stride         (stride),
    .kern_addr_mode (kern_addr_mode),
    .shift          (shift),
    .en_max_pool    (en_max_pool),
    .signed_mode    (signed_mode),
    .en_relu        (en_relu),
    .mask           (mask),
    .img_rd_en      (img_rd_en),
    .img_addr       (img_addr),
    .img_rdata      (img_rdata),
    .kern_rd_en     (kern_rd_en),
    .kern_addr      (kern_addr),
    .kern_rdata     (kern_rdata),
    .rslt_we        (rslt_we),
    .rslt_addr      (rslt_addr),
    .rslt_wdata     (rslt_wdata),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
  );

  // Synchronous-read RAM models (data one cycle after the strobe)
  always @(posedge clk) begin
    if (img_rd_en)  img_rdata  <= img_mem[img_addr];
    if (kern_rd_en) kern_rdata <= kern_mem[kern_addr];
  end

  // Result capture, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (rslt_we) begin
      got_d.push_back(rslt_wdata);
      got_a.push_back(rslt_addr);
      got_c.push_back(cyc);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: straight nested loops over kernels/columns/taps/channels,
  // then pooling applied to each kernel's list of outputs.
  task automatic model_run();
    longint outs[$];
    longint acc, y, lo, hi, v;
    int     st, ia, ka, p, w, idx;
    exp_d.delete();
    exp_ovf = 0;
    st = (stride == 0) ? 1 : int'(stride);
    hi = signed_mode ? (64'sd1 <<< 19) - 1 : (64'sd1 <<< 20) - 1;
    lo = signed_mode ? -(64'sd1 <<< 19) : 0;
    for (int ks = 0; ks <= int'(kerns_m1); ks++) begin
      outs.delete();
      for (int c = 0; c <= int'(cols_m1); c += st) begin
        acc = 0;
        for (int k = 0; k <= int'(kern_cols_m1); k++) begin
          ia = (c + k) % 256;
          ka = (ks * (kern_addr_mode ? 8 : 4) + k) % 32;
          for (int ch = 0; ch < 3; ch++) begin
            if (mask[ch]) begin
              p = int'(img_mem[ia][8*ch +: 8]);
              w = int'(kern_mem[ka][8*ch +: 8]);
              if (signed_mode && w > 127) w -= 256;
              acc += longint'(p) * longint'(w);
            end
          end
        end
        y = acc >>> shift;
        if (en_relu && y < 0) y = 0;
        if (y > hi) begin y = hi; exp_ovf = 1; end
        if (y < lo) begin y = lo; exp_ovf = 1; end
        outs.push_back(y);
      end
      idx = 0;
      while (idx < outs.size()) begin
        if (en_max_pool && idx + 1 < outs.size()) begin
          v = (outs[idx] > outs[idx+1]) ? outs[idx] : outs[idx+1];
          idx += 2;
        end else begin
          v = outs[idx];
          idx += en_max_pool ? 2 : 1;
        end
        exp_d.push_back(v[19:0]);
      end
    end
  endtask

  task automatic set_cfg(input int kc, input int cm, input int km, input int st,
                         input bit km8, input int sh, input bit pool,
                         input bit sgn, input bit relu, input logic [2:0] mk);
    kern_cols_m1   = kc[2:0];
    cols_m1        = cm[7:0];
    kerns_m1       = km[2:0];
    stride         = st[7:0];
    kern_addr_mode = km8;
    shift          = sh[3:0];
    en_max_pool    = pool;
    signed_mode    = sgn;
    en_relu        = relu;
    mask           = mk;
  endtask

  task automatic do_run(input string tag, input bit chk_timing, input bit keep_start);
    bit ok;
    int nw;
    model_run();
    got_d.delete();
    got_a.delete();
    got_c.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk({tag, "_busy_launch"}, busy, 1);
    ok = 0;
    for (int n = 0; n < LIMIT; n++) begin
      if (done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, ok, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_nwrites"}, got_d.size(), exp_d.size());
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
      chk($sformatf("%s_addr%0d", tag, i), got_a[i], i % 256);
    end
    chk({tag, "_overflow"}, overflow, exp_ovf);
    if (chk_timing) begin
      for (int i = 1; i < got_c.size(); i++)
        chk($sformatf("%s_period%0d", tag, i), got_c[i] - got_c[i-1], int'(kern_cols_m1) + 4);
    end
    if (keep_start) begin
      nw = got_d.size();
      repeat (20) @(negedge clk);
      chk({tag, "_no_relaunch_wr"}, got_d.size(), nw);
      chk({tag, "_done_held"}, done, 1);
      chk({tag, "_busy_held"}, busy, 0);
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_done_clear"}, done, 0);
  endtask

  initial begin
    int nw;
    rst_n    = 1'b0;
    soft_rst = 1'b0;
    start    = 1'b0;
    set_cfg(0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b111);
    for (int i = 0; i < 256; i++) img_mem[i] = '0;
    for (int i = 0; i < 32; i++)  kern_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_we", rslt_we, 0);
    chk("rst_rd", {img_rd_en, kern_rd_en}, 0);
    chk("rst_addrs", {img_addr, kern_addr, rslt_addr}, 0);
    chk("rst_wdata", rslt_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: unit data, K=2, four columns, pool off
    for (int i = 0; i < 256; i++) img_mem[i] = 24'h010101;
    for (int i = 0; i < 32; i++)  kern_mem[i] = 24'h010101;
    set_cfg(1, 3, 0, 1, 0, 0, 0, 0, 0, 3'b111);
    do_run("t1", 1, 0);
    if (got_d.size() > 0) chk("t1_val6", got_d[0], 20'd6);

    // T2: ramp data, pool on
    for (int i = 0; i < 256; i++) img_mem[i] = {3{i[7:0]}};
    set_cfg(1, 3, 0, 1, 0, 0, 1, 0, 0, 3'b111);
    do_run("t2", 0, 0);
    if (got_d.size() == 2) begin
      chk("t2_val9", got_d[0], 20'd9);
      chk("t2_val21", got_d[1], 20'd21);
    end

    // T3: stride 2 with unpaired tail
    set_cfg(1, 4, 0, 2, 0, 0, 1, 0, 0, 3'b111);
    do_run("t3", 0, 0);
    if (got_d.size() == 2) chk("t3_tail27", got_d[1], 20'd27);

    // T4: signed weights of -1, without and with ReLU
    for (int i = 0; i < 32; i++) kern_mem[i] = 24'hFFFFFF;
    set_cfg(1, 3, 0, 1, 0, 0, 0, 1, 0, 3'b111);
    do_run("t4", 1, 0);
    if (got_d.size() > 0) chk("t4_neg3", got_d[0], 20'hFFFFD);
    set_cfg(1, 3, 0, 1, 0, 0, 0, 1, 1, 3'b111);
    do_run("t4r", 0, 0);

    // T5: full-scale saturation, then shift back into range
    for (int i = 0; i < 256; i++) img_mem[i] = 24'hFFFFFF;
    set_cfg(7, 0, 0, 1, 0, 0, 0, 0, 0, 3'b111);
    do_run("t5", 0, 0);
    chk("t5_ovf_set", overflow, 1);
    if (got_d.size() > 0) chk("t5_sat", got_d[0], 20'hFFFFF);
    set_cfg(7, 0, 0, 1, 0, 1, 0, 0, 0, 3'b111);
    do_run("t5s", 0, 0);
    if (got_d.size() > 0) chk("t5s_val", got_d[0], 20'd780300);

    // T6: soft reset mid-run, then start-hold and relaunch behaviour
    for (int i = 0; i < 256; i++) img_mem[i] = {3{i[7:0]}};
    for (int i = 0; i < 32; i++)  kern_mem[i] = 24'h010101;
    set_cfg(1, 20, 1, 1, 0, 0, 0, 0, 0, 3'b111);
    got_d.delete();
    @(negedge clk);
    start = 1'b1;
    repeat (12) @(negedge clk);
    soft_rst = 1'b1;
    start    = 1'b0;
    @(negedge clk);
    soft_rst = 1'b0;
    nw = got_d.size();
    repeat (100) @(negedge clk);
    chk("t6_no_writes", got_d.size(), nw);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_raddr", rslt_addr, 0);
    set_cfg(1, 5, 1, 1, 0, 0, 1, 0, 0, 3'b111);
    do_run("t6b", 0, 1);
    do_run("t6c", 0, 0);

    // Randomized configurations and RAM contents
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 256; i++) img_mem[i] = 24'($urandom);
      for (int i = 0; i < 32; i++)  kern_mem[i] = 24'($urandom);
      set_cfg($urandom_range(0, 7), $urandom_range(0, 12), $urandom_range(0, 2),
              $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 6),
              1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom_range(1, 7)));
      do_run($sformatf("rnd%0d", r), !en_max_pool, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
